// File: rtl/uart_pkg.sv
// Shared UART sizing constants, used by the TX buffer, the TX FIFO and the RX FIFO.
package uart_pkg;

  localparam int BYTE_WIDTH    = 8;
  localparam int TX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word-fall-through read port and a synchronous flush.
// Full/empty come from wrap-bit pointers, so no separate occupancy register is kept.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = BYTE_WIDTH,
  parameter  int DEPTH      = TX_FIFO_DEPTH,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  full,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;
  logic                  push, pop;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count = CNT_WIDTH'(wr_ptr_q - rd_ptr_q);

  assign inReady  = !full;
  assign outValid = !empty;
  assign data_out = mem_q[rd_addr];

  assign push = inValid && !full && !clear;
  assign pop  = outReady && !empty && !clear;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; empty pointers keep stale entries from ever being presented.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= data_in;
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, fill/drain, full-boundary, streaming, clear and mid-stream reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       inValid;
  logic       inReady;
  logic       full;
  logic [7:0] data_in;
  logic       outValid;
  logic       outReady;
  logic [7:0] data_out;
  logic       empty;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .inValid  (inValid),
    .inReady  (inReady),
    .full     (full),
    .data_in  (data_in),
    .outValid (outValid),
    .outReady (outReady),
    .data_out (data_out),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " empty"},    32'(empty),    1);
    check({tag, " full"},     32'(full),     0);
    check({tag, " inReady"},  32'(inReady),  1);
    check({tag, " outValid"}, 32'(outValid), 0);
    check({tag, " count"},    32'(count),    0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    inValid = 1'b1;
    data_in = b;
    step();
    inValid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] b);
    check({tag, " outValid"}, 32'(outValid), 1);
    check({tag, " data_out"}, 32'(data_out), 32'(b));
    outReady = 1'b1;
    step();
    outReady = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    clear    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    data_in  = 8'h00;
    #1;
    check_idle("in_reset");
    step();
    step();
    rst = 1'b1;
    step();

    // 1: idle, then single-byte latency
    check_idle("idle");
    push_byte(8'hA5);
    check("lat outValid", 32'(outValid), 1);
    check("lat data_out", 32'(data_out), 32'hA5);
    check("lat count",    32'(count),    1);
    pop_expect("lat pop", 8'hA5);
    check_idle("lat drained");

    // 2: fill to 16, overflow push ignored, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill full",    32'(full),    1);
    check("fill inReady", 32'(inReady), 0);
    check("fill count",   32'(count),   16);
    push_byte(8'hFF);
    check("ovf count",    32'(count),    16);
    check("ovf data_out", 32'(data_out), 0);
    for (int i = 0; i < 16; i++) pop_expect("drain", 8'(i));
    check_idle("drain done");

    // 3: push+pop while full: pop only, held byte taken next cycle
    for (int i = 0; i < 16; i++) push_byte(8'(32'h20 + i));
    inValid  = 1'b1;
    data_in  = 8'h55;
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check("fullpp count",    32'(count),    15);
    check("fullpp inReady",  32'(inReady),  1);
    check("fullpp data_out", 32'(data_out), 32'h21);
    step();
    inValid = 1'b0;
    check("held count", 32'(count), 16);
    check("held full",  32'(full),  1);
    for (int i = 1; i < 16; i++) pop_expect("fullpp drain", 8'(32'h20 + i));
    pop_expect("fullpp held", 8'h55);
    check_idle("fullpp done");

    // 4: half-full streaming for 40 cycles, pointers wrap twice
    for (int i = 0; i < 8; i++) push_byte(8'(32'h40 + i));
    check("half count", 32'(count), 8);
    for (int k = 0; k < 40; k++) begin
      check("stream data_out", 32'(data_out), 32'h40 + k);
      inValid  = 1'b1;
      outReady = 1'b1;
      data_in  = 8'(32'h48 + k);
      step();
      check("stream count", 32'(count), 8);
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < 8; i++) pop_expect("stream drain", 8'(32'h68 + i));
    check_idle("stream done");

    // 5: clear beats simultaneous push and pop
    for (int i = 0; i < 5; i++) push_byte(8'(32'h70 + i));
    check("preclr count", 32'(count), 5);
    clear    = 1'b1;
    inValid  = 1'b1;
    outReady = 1'b1;
    data_in  = 8'h3C;
    step();
    clear    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    check_idle("clr");
    push_byte(8'h11);
    check("postclr data_out", 32'(data_out), 32'h11);
    check("postclr count",    32'(count),    1);
    pop_expect("postclr pop", 8'h11);

    // 6: asynchronous reset with 7 queued bytes
    for (int i = 0; i < 7; i++) push_byte(8'(32'h80 + i));
    check("prerst count", 32'(count), 7);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async rst");
    step();
    rst = 1'b1;
    step();
    check_idle("post rst");
    push_byte(8'h99);
    check("post rst data_out", 32'(data_out), 32'h99);
    check("post rst count",    32'(count),    1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-wide synchronous FIFO between the word-to-byte TX buffer and the UART serializer. It accepts bytes on a valid/ready write port and presents them first-word-fall-through on a valid/ready read port. It reports full, empty and occupancy to the TX buffer and the status register. A synchronous clear, driven by the control-register TX FIFO reset bit, empties it.

Parameters:
DATA_WIDTH, 8, byte width of each entry
DEPTH, 16, number of entries; power of two, at least 2
CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
clear  input  1  synchronous FIFO flush, one-cycle pulse or level
inValid  input  1  write request from the TX buffer
inReady  output  1  write ready; equals !full
full  output  1  FIFO holds DEPTH entries
data_in  input  DATA_WIDTH  byte to write
outValid  output  1  head byte available; equals !empty
outReady  input  1  serializer pops the head byte
data_out  output  DATA_WIDTH  head byte, first-word-fall-through
empty  output  1  FIFO holds 0 entries
count  output  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset:
  - All state is on the posedge of clk. rst is asynchronous and active-low.
  - During and after reset: count=0, empty=1, full=0, inReady=1, outValid=0.
  - Pointers reset to 0. Memory contents are not reset.
  - data_out is don't-care while outValid=0. The bench must not check it then.
- Storage:
  - Register array of DEPTH x DATA_WIDTH.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide. The extra bit is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) && (wrap bits differ).
  - count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Push:
  - A push occurs when inValid && !full.
  - The byte is written at wr_ptr[addr] and wr_ptr increments, wrapping naturally.
  - inValid while full is ignored: no write, no pointer change, no error flag.
  - The upstream block is responsible for holding the byte until it is accepted.
- Pop:
  - A pop occurs when outReady && !empty, and rd_ptr increments.
  - data_out = mem[rd_ptr[addr]] combinationally, so the head is visible without a read command.
- Latency: a byte pushed into an empty FIFO in cycle N gives outValid=1 with that byte in cycle N+1.
- Simultaneous push and pop:
  - When neither full nor empty, both happen and count is unchanged.
  - When full, the pop happens but the push is refused. inReady is computed from registered full and does not look ahead at the pop. inReady rises the following cycle.
  - When empty, the push happens but no pop occurs. outValid is low that cycle.
- Clear:
  - Synchronous and higher priority than push or pop in the same cycle.
  - Both pointers go to 0, so empty=1 and count=0 in the next cycle.
  - A byte offered in the clear cycle is discarded.
- Reset mid-operation: all queued bytes are lost and outputs return to reset values asynchronously.
- No FSM is required. State is fully captured by the two pointers.
- Ordering: strict FIFO. Bytes leave in the exact order accepted.

Decomposition:
- Shared package uart_pkg holds:
  - BYTE_WIDTH = 8
  - TX_FIFO_DEPTH = 16
  - RX_FIFO_DEPTH = 16
- These defaults are reused by the TX buffer and by the future RX FIFO.
- No sub-module is needed. The storage array and pointer logic stay inline so that the same module can be instantiated for the RX path.

Test Plan:
1. Reset, then idle: empty=1, full=0, inReady=1, outValid=0, count=0. Then push 0xA5 at cycle N: outValid=1, data_out=0xA5, count=1 at N+1.
2. Push 16 bytes 0x00..0x0F with outReady=0:
   - full=1, inReady=0, count=16.
   - A 17th push of 0xFF is ignored.
   - Then pop all 16: outputs 0x00..0x0F in order, and the 0xFF byte never appears.
3. Full FIFO with inValid=1 and outReady=1 in the same cycle: pop occurs and the push is refused, so count=15. The held byte is accepted on the next cycle, giving count=16.
4. Half-full (count=8) with continuous push and pop for 40 cycles:
   - count stays 8.
   - Pointers wrap at least twice.
   - Output sequence matches the input sequence.
5. count=5, then assert clear together with inValid=1 (data 0x3C) and outReady=1:
   - Next cycle: empty=1, count=0, outValid=0.
   - A subsequent push of 0x11 appears as the next data_out.
6. Assert rst low mid-stream with count=7: outputs go to reset values asynchronously before the next clk edge. After release, no stale byte is presented.
